// File: rtl/histogram_pkg.sv
// Shared types and default parameter values for the histogram engine.
package histogram_pkg;

   localparam int DEF_BIN_W         = 7;
   localparam int DEF_CNT_W         = 7;
   localparam bit DEF_SATURATE      = 1'b1;
   localparam bit DEF_CLEAR_ON_READ = 1'b1;

   typedef enum logic [1:0] {
      S_CLEAR,
      S_ACCUM,
      S_FLUSH,
      S_READ
   } hist_state_e;

endpackage

// File: rtl/histogram_engine_if.sv
// Sample input, readout stream and status bundle of the histogram engine.
interface histogram_engine_if
   import histogram_pkg::*;
#(
   parameter int BIN_W = DEF_BIN_W,
   parameter int CNT_W = DEF_CNT_W
);

   logic [BIN_W-1:0] d_in;
   logic             d_valid;
   logic             d_ready;
   logic             rd_start;
   logic             rd_valid;
   logic             rd_ready;
   logic [BIN_W-1:0] rd_bin;
   logic [CNT_W-1:0] rd_count;
   logic             rd_last;
   logic             sat_flag;

   modport master (
      output d_in, d_valid, rd_start, rd_ready,
      input  d_ready, rd_valid, rd_bin, rd_count, rd_last, sat_flag
   );

   modport slave (
      input  d_in, d_valid, rd_start, rd_ready,
      output d_ready, rd_valid, rd_bin, rd_count, rd_last, sat_flag
   );

endinterface

// File: rtl/hist_ram.sv
// Simple dual-port counter storage: synchronous write, registered read.
// A read and a write to the same address in one cycle returns the old value.
module hist_ram
   import histogram_pkg::*;
#(
   parameter int ADDR_W = DEF_BIN_W,
   parameter int DATA_W = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   // Write port
   // NOTE: the array has no reset branch so it maps onto RAM; the engine's
   // CLEAR sweep zeroes it after every reset instead.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // Registered read port; holds its value while rd_en is low
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     rd_data <= '0;
      else if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/histogram_engine.sv
// Histogram engine: sweeps the bin memory clear, counts samples per bin with
// a forwarded read-modify-write pipeline, then streams all bins out in order.
module histogram_engine
   import histogram_pkg::*;
#(
   parameter int BIN_W         = DEF_BIN_W,
   parameter int CNT_W         = DEF_CNT_W,
   parameter bit SATURATE      = DEF_SATURATE,
   parameter bit CLEAR_ON_READ = DEF_CLEAR_ON_READ
) (
   input logic               clk,
   input logic               rst_n,
   histogram_engine_if.slave bus
);

   localparam int               NBINS    = 2**BIN_W;
   localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(NBINS - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   hist_state_e      state_q, state_d;
   logic [BIN_W-1:0] addr_q;          // clear sweep and readout fetch address
   logic             fetch_done_q;
   logic             rd_valid_q, rd_last_q;
   logic [BIN_W-1:0] rd_bin_q;
   logic             s1_valid_q;
   logic [BIN_W-1:0] s1_bin_q;
   logic             fwd_valid_q;     // a stage-2 write landed on the edge s1 was read
   logic [BIN_W-1:0] fwd_bin_q;
   logic [CNT_W-1:0] fwd_data_q;
   logic             sat_q;

   logic             accept, fetch, hshake, at_max, inc_sat;
   logic [CNT_W-1:0] ram_rd_data, base, inc;
   logic             wr_en, rd_en;
   logic [BIN_W-1:0] wr_addr, rd_addr;
   logic [CNT_W-1:0] wr_data;

   hist_ram #(.ADDR_W(BIN_W), .DATA_W(CNT_W)) u_ram (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .rd_data (ram_rd_data)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_CLEAR;
      else        state_q <= state_d;
   end

   // Next state plus per-state handshake qualifiers
   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      fetch   = 1'b0;
      hshake  = rd_valid_q & bus.rd_ready;
      case (state_q)
         S_CLEAR: if (addr_q == LAST_BIN) state_d = S_ACCUM;
         S_ACCUM: begin
            accept = bus.d_valid;
            if (bus.rd_start) state_d = S_FLUSH;
         end
         S_FLUSH: state_d = S_READ;
         S_READ: begin
            fetch = !fetch_done_q && (!rd_valid_q || bus.rd_ready);
            if (hshake && rd_last_q) state_d = S_ACCUM;
         end
         default: state_d = S_CLEAR;
      endcase
   end

   // Stage 2 increment with forwarding and saturate/wrap handling
   always_comb begin
      base    = (fwd_valid_q && fwd_bin_q == s1_bin_q) ? fwd_data_q : ram_rd_data;
      at_max  = (base == CNT_MAX);
      inc     = at_max ? (SATURATE ? CNT_MAX : '0) : base + 1'b1;
      inc_sat = SATURATE ? (inc == CNT_MAX) : at_max;
   end

   // Memory port steering: clear sweep, counter update, clear-on-read
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = addr_q;
      wr_data = '0;
      if (state_q == S_CLEAR) begin
         wr_en = 1'b1;
      end else if (s1_valid_q) begin
         wr_en   = 1'b1;
         wr_addr = s1_bin_q;
         wr_data = inc;
      end else if (CLEAR_ON_READ && state_q == S_READ && hshake) begin
         wr_en   = 1'b1;
         wr_addr = rd_bin_q;
      end
      rd_en   = accept | fetch;
      rd_addr = (state_q == S_READ) ? addr_q : bus.d_in;
   end

   // Pipeline, sweep address, readout registers and sticky saturation flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q       <= '0;
         fetch_done_q <= 1'b0;
         rd_valid_q   <= 1'b0;
         rd_last_q    <= 1'b0;
         rd_bin_q     <= '0;
         s1_valid_q   <= 1'b0;
         s1_bin_q     <= '0;
         fwd_valid_q  <= 1'b0;
         fwd_bin_q    <= '0;
         fwd_data_q   <= '0;
         sat_q        <= 1'b0;
      end else begin
         s1_valid_q  <= accept;
         if (accept) s1_bin_q <= bus.d_in;
         fwd_valid_q <= s1_valid_q;
         fwd_bin_q   <= s1_bin_q;
         fwd_data_q  <= inc;
         if (s1_valid_q && inc_sat) sat_q <= 1'b1;
         case (state_q)
            S_CLEAR: addr_q <= addr_q + 1'b1;
            S_FLUSH: begin
               addr_q       <= '0;
               fetch_done_q <= 1'b0;
            end
            S_READ: begin
               if (fetch) begin
                  rd_valid_q <= 1'b1;
                  rd_bin_q   <= addr_q;
                  rd_last_q  <= (addr_q == LAST_BIN);
                  addr_q     <= addr_q + 1'b1;
                  if (addr_q == LAST_BIN) fetch_done_q <= 1'b1;
               end else if (hshake) begin
                  rd_valid_q <= 1'b0;
                  rd_last_q  <= 1'b0;
               end
               if (CLEAR_ON_READ && hshake && rd_last_q) sat_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign bus.d_ready  = (state_q == S_ACCUM);
   assign bus.rd_valid = rd_valid_q;
   assign bus.rd_bin   = rd_bin_q;
   assign bus.rd_count = ram_rd_data;
   assign bus.rd_last  = rd_last_q;
   assign bus.sat_flag = sat_q;

endmodule
